// File: rtl/a1339_pkg.sv
// Shared definitions for the A1339 angle-sensor SPI link: frame size,
// response bit positions, state encoding and the parity helper.
package a1339_pkg;

   localparam int A1339_FRAME_BITS = 16;

   // Command word fields
   localparam int A1339_RW_BIT   = 15;
   localparam int A1339_ADDR_MSB = 13;
   localparam int A1339_ADDR_LSB = 8;

   // Response word fields
   localparam int A1339_EF_BIT = 15;
   localparam int A1339_ND_BIT = 14;
   localparam int A1339_P_BIT  = 13;

   localparam logic [5:0] A1339_ANGLE_ADDR = 6'h20;

   typedef logic [A1339_FRAME_BITS-1:0] a1339_word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } spi_state_e;

   // Value for the P bit that makes the whole word odd parity.
   // The word must be passed in with its P bit still zero.
   function automatic logic a1339_odd_parity(input a1339_word_t w);
      return ~(^w);
   endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Synchronises the asynchronous SPI pins into the system clock domain and
// produces one-cycle edge pulses for sck and ss_n. SYNC_STAGES must be >= 2.
module spi_input_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic ss_n_i,
   input  logic sck_i,
   input  logic mosi_i,
   output logic ss_n_o,
   output logic mosi_o,
   output logic sck_rise_o,
   output logic sck_fall_o,
   output logic ss_fall_o,
   output logic ss_rise_o
);

   logic [SYNC_STAGES-1:0] ss_sh;
   logic [SYNC_STAGES-1:0] sck_sh;
   logic [SYNC_STAGES-1:0] mosi_sh;
   logic                   ss_d;
   logic                   sck_d;
   logic                   sck_s;

   assign ss_n_o = ss_sh[SYNC_STAGES-1];
   assign sck_s  = sck_sh[SYNC_STAGES-1];
   assign mosi_o = mosi_sh[SYNC_STAGES-1];

   assign sck_rise_o =  sck_s & ~sck_d;
   assign sck_fall_o = ~sck_s &  sck_d;
   assign ss_fall_o  = ~ss_n_o &  ss_d;
   assign ss_rise_o  =  ss_n_o & ~ss_d;

   // Synchroniser chains plus one delayed copy for edge detection. ss_n resets
   // low so a frame already in progress at reset never shows a falling edge;
   // sck resets high (mode 3 idle level).
   always_ff @(posedge clock) begin
      if (reset) begin
         ss_sh   <= '0;
         sck_sh  <= '1;
         mosi_sh <= '0;
         ss_d    <= 1'b0;
         sck_d   <= 1'b1;
      end else begin
         ss_sh   <= {ss_sh[SYNC_STAGES-2:0], ss_n_i};
         sck_sh  <= {sck_sh[SYNC_STAGES-2:0], sck_i};
         mosi_sh <= {mosi_sh[SYNC_STAGES-2:0], mosi_i};
         ss_d    <= ss_n_o;
         sck_d   <= sck_s;
      end
   end

endmodule

// File: rtl/a1339_spi_responder.sv
// SPI mode-3 responder emulating one A1339 angle sensor. Reads are answered
// out-of-frame: a read command selects the word sent in the following frame.
// cmd_valid_o is a one-cycle pulse with no back-pressure; cmd_data_o is
// valid in that cycle and holds until the next good frame.
module a1339_spi_responder
   import a1339_pkg::*;
#(
   parameter int         REG_COUNT   = 4,
   parameter logic [5:0] ANGLE_ADDR  = A1339_ANGLE_ADDR,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] angle_i,
   input  logic        angle_valid_i,
   input  logic        ss_n_i,
   input  logic        sck_i,
   input  logic        mosi_i,
   output logic        miso_o,
   output logic        miso_oe_o,
   output logic        cmd_valid_o,
   output logic [15:0] cmd_data_o,
   output logic        frame_error_o,
   output logic [15:0] frame_count_o,
   output spi_state_e  dbg_state_o
);

   localparam int         AW        = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
   localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);
   localparam logic [4:0] FULL_CNT  = 5'(A1339_FRAME_BITS);
   localparam logic [4:0] SAT_CNT   = 5'(A1339_FRAME_BITS + 1);

   logic        ss_n_s, mosi_s, sck_rise, sck_fall, ss_fall, ss_rise;
   spi_state_e  state_q, state_d;
   logic        armed_q;
   a1339_word_t tx_q, rx_q, resp_w;
   logic [4:0]  bit_cnt_q;
   logic        seen_rise_q;
   logic        miso_q;
   logic [5:0]  pending_q;
   logic [11:0] angle_q;
   logic        nd_q;
   logic [7:0]  cfg_q [REG_COUNT];
   logic [5:0]  cmd_addr;

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clock      (clock),
      .reset      (reset),
      .ss_n_i     (ss_n_i),
      .sck_i      (sck_i),
      .mosi_i     (mosi_i),
      .ss_n_o     (ss_n_s),
      .mosi_o     (mosi_s),
      .sck_rise_o (sck_rise),
      .sck_fall_o (sck_fall),
      .ss_fall_o  (ss_fall),
      .ss_rise_o  (ss_rise)
   );

   assign cmd_addr    = rx_q[A1339_ADDR_MSB:A1339_ADDR_LSB];
   assign miso_o      = miso_q;
   // armed_q keeps the output disabled for a frame cut short by reset.
   assign miso_oe_o   = armed_q & ~ss_n_s;
   assign dbg_state_o = state_q;

   // Frame state register.
   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; a frame only starts once ss_n has been seen high.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ss_fall && armed_q) state_d = LOAD;
         LOAD:    state_d = ss_rise ? DONE : SHIFT;
         SHIFT:   if (ss_rise) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Response word for the pending address, with parity filled in last.
   always_comb begin
      resp_w = '0;
      if (pending_q == ANGLE_ADDR) begin
         resp_w[A1339_ND_BIT] = nd_q;
         resp_w[11:0]         = angle_q;
      end else if (pending_q < REG_LIMIT) begin
         resp_w[7:0] = cfg_q[pending_q[AW-1:0]];
      end else begin
         resp_w[A1339_EF_BIT] = 1'b1;
      end
      resp_w[A1339_P_BIT] = a1339_odd_parity(resp_w);
   end

   // Shifters, angle capture, register file and frame-end decode.
   always_ff @(posedge clock) begin
      if (reset) begin
         armed_q       <= 1'b0;
         tx_q          <= '1;
         rx_q          <= '0;
         bit_cnt_q     <= '0;
         seen_rise_q   <= 1'b0;
         miso_q        <= 1'b1;
         pending_q     <= ANGLE_ADDR;
         angle_q       <= '0;
         nd_q          <= 1'b0;
         cmd_valid_o   <= 1'b0;
         cmd_data_o    <= '0;
         frame_error_o <= 1'b0;
         frame_count_o <= '0;
         for (int i = 0; i < REG_COUNT; i++) cfg_q[i] <= '0;
      end else begin
         cmd_valid_o   <= 1'b0;
         frame_error_o <= 1'b0;
         if (ss_n_s) armed_q <= 1'b1;

         // A strobe coinciding with LOAD wins, so the flag is left set.
         if (state_q == LOAD && pending_q == ANGLE_ADDR) nd_q <= 1'b0;
         if (angle_valid_i) begin
            angle_q <= angle_i;
            nd_q    <= 1'b1;
         end

         case (state_q)
            LOAD: begin
               tx_q        <= resp_w;
               miso_q      <= resp_w[A1339_FRAME_BITS-1];
               bit_cnt_q   <= '0;
               seen_rise_q <= 1'b0;
            end
            SHIFT: begin
               if (sck_rise) begin
                  rx_q        <= {rx_q[A1339_FRAME_BITS-2:0], mosi_s};
                  seen_rise_q <= 1'b1;
                  if (bit_cnt_q != SAT_CNT) bit_cnt_q <= bit_cnt_q + 5'd1;
               end
               // Ones shift in behind the data so miso idles high after bit 0.
               if (sck_fall && seen_rise_q) begin
                  miso_q <= tx_q[A1339_FRAME_BITS-2];
                  tx_q   <= {tx_q[A1339_FRAME_BITS-2:0], 1'b1};
               end
            end
            DONE: begin
               miso_q <= 1'b1;
               if (bit_cnt_q == FULL_CNT) begin
                  cmd_data_o    <= rx_q;
                  cmd_valid_o   <= 1'b1;
                  frame_count_o <= frame_count_o + 16'd1;
                  if (!rx_q[A1339_RW_BIT]) pending_q <= cmd_addr;
                  else if (cmd_addr < REG_LIMIT) cfg_q[cmd_addr[AW-1:0]] <= rx_q[7:0];
               end else begin
                  frame_error_o <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_a1339_spi_responder.sv
// Directed bench for the A1339 SPI responder: a mode-3 master driver pushes
// the hand-computed expected command, response word and frame count per
// frame; a monitor pops and compares on cmd_valid_o / frame_error_o.
module tb_a1339_spi_responder;
  import a1339_pkg::*;

  localparam int HALF = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] angle_i;
  logic        angle_valid_i;
  logic        ss_n_i, sck_i, mosi_i;
  logic        miso_o, miso_oe_o, cmd_valid_o, frame_error_o;
  logic [15:0] cmd_data_o, frame_count_o;
  spi_state_e  dbg_state_o;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_cmd_q[$];
  logic [15:0] exp_miso_q[$];
  logic [15:0] exp_cnt_q[$];
  logic [15:0] exp_err_q[$];
  logic [15:0] cap_q[$];

  a1339_spi_responder dut (
    .clock         (clock),
    .reset         (reset),
    .angle_i       (angle_i),
    .angle_valid_i (angle_valid_i),
    .ss_n_i        (ss_n_i),
    .sck_i         (sck_i),
    .mosi_i        (mosi_i),
    .miso_o        (miso_o),
    .miso_oe_o     (miso_oe_o),
    .cmd_valid_o   (cmd_valid_o),
    .cmd_data_o    (cmd_data_o),
    .frame_error_o (frame_error_o),
    .frame_count_o (frame_count_o),
    .dbg_state_o   (dbg_state_o)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic spi_bits(input logic [15:0] cmd, input int nbits, output logic [15:0] cap);
    cap = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clock);
      sck_i  = 1'b0;
      mosi_i = cmd[15-i];
      repeat (HALF) @(negedge clock);
      sck_i = 1'b1;
      cap   = {cap[14:0], miso_o};
      repeat (HALF) @(negedge clock);
    end
  endtask

  task automatic spi_frame(input logic [15:0] cmd, input int nbits, input bit keep);
    logic [15:0] cap;
    ss_n_i = 1'b0;
    repeat (HALF) @(negedge clock);
    if (keep) check("miso_oe_in_frame", {15'b0, miso_oe_o}, 16'h0001);
    spi_bits(cmd, nbits, cap);
    repeat (HALF) @(negedge clock);
    if (keep) cap_q.push_back(cap);
    ss_n_i = 1'b1;
    repeat (2 * HALF) @(negedge clock);
  endtask

  task automatic full_frame(input logic [15:0] cmd, input logic [15:0] miso_w, input logic [15:0] cnt);
    exp_cmd_q.push_back(cmd);
    exp_miso_q.push_back(miso_w);
    exp_cnt_q.push_back(cnt);
    spi_frame(cmd, 16, 1'b1);
  endtask

  task automatic strobe_angle(input logic [11:0] a);
    @(negedge clock);
    angle_i       = a;
    angle_valid_i = 1'b1;
    @(negedge clock);
    angle_valid_i = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (cmd_valid_o) begin
        if (exp_cmd_q.size() == 0 || cap_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cmd_valid: got cmd %h expected no pulse", cmd_data_o);
        end else begin
          check("cmd_data", cmd_data_o, exp_cmd_q.pop_front());
          check("miso_word", cap_q.pop_front(), exp_miso_q.pop_front());
          check("frame_count", frame_count_o, exp_cnt_q.pop_front());
        end
      end
      if (frame_error_o) begin
        if (exp_err_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame_error: got pulse expected none");
        end else begin
          check("frame_count_on_error", frame_count_o, exp_err_q.pop_front());
        end
      end
    end
  end

  // main sequence
  initial begin
    int t;
    logic [15:0] junk;
    reset         = 1'b1;
    angle_i       = '0;
    angle_valid_i = 1'b0;
    ss_n_i        = 1'b1;
    sck_i         = 1'b1;
    mosi_i        = 1'b0;
    repeat (4) @(negedge clock);
    check("rst_miso", {15'b0, miso_o}, 16'h0001);
    check("rst_oe", {15'b0, miso_oe_o}, 16'h0000);
    check("rst_cmd_valid", {15'b0, cmd_valid_o}, 16'h0000);
    check("rst_cmd_data", cmd_data_o, 16'h0000);
    check("rst_frame_error", {15'b0, frame_error_o}, 16'h0000);
    check("rst_frame_count", frame_count_o, 16'h0000);
    check("rst_state", {14'b0, dbg_state_o}, {14'b0, IDLE});
    reset = 1'b0;
    repeat (10) @(negedge clock);

    // Angle read, ND clear, config write/read, bad address
    full_frame(16'h2000, 16'h2000, 16'd1);
    strobe_angle(12'hABC);
    full_frame(16'h0000, 16'h6ABC, 16'd2);
    full_frame(16'h2000, 16'h2000, 16'd3);
    full_frame(16'h8155, 16'h0ABC, 16'd4);
    full_frame(16'h0100, 16'h0ABC, 16'd5);
    full_frame(16'h3F00, 16'h2055, 16'd6);
    full_frame(16'h0000, 16'h8000, 16'd7);

    // Short frame: error pulse, nothing decoded
    exp_err_q.push_back(16'd7);
    spi_frame(16'h0100, 9, 1'b0);
    check("cmd_data_hold_after_short", cmd_data_o, 16'h0000);
    check("oe_after_frame", {15'b0, miso_oe_o}, 16'h0000);
    full_frame(16'h2000, 16'h2000, 16'd8);

    // Reset in the middle of a frame
    ss_n_i = 1'b0;
    repeat (HALF) @(negedge clock);
    spi_bits(16'h8203, 5, junk);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("midrst_miso", {15'b0, miso_o}, 16'h0001);
    check("midrst_oe", {15'b0, miso_oe_o}, 16'h0000);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("postrst_oe_still_selected", {15'b0, miso_oe_o}, 16'h0000);
    spi_bits(16'hFFFF, 3, junk);
    repeat (HALF) @(negedge clock);
    ss_n_i = 1'b1;
    repeat (2 * HALF) @(negedge clock);
    check("postrst_state", {14'b0, dbg_state_o}, {14'b0, IDLE});
    check("postrst_frame_count", frame_count_o, 16'h0000);
    check("postrst_cmd_data", cmd_data_o, 16'h0000);

    // Normal decode after reset, ignored high write address, rx[14] ignored
    strobe_angle(12'h123);
    full_frame(16'h8203, 16'h4123, 16'd1);
    full_frame(16'h0200, 16'h2123, 16'd2);
    full_frame(16'h0000, 16'h2003, 16'd3);
    full_frame(16'h8555, 16'h2000, 16'd4);
    full_frame(16'h0100, 16'h2000, 16'd5);
    full_frame(16'h4200, 16'h2000, 16'd6);
    full_frame(16'h0000, 16'h2003, 16'd7);

    t = 0;
    while ((exp_cmd_q.size() != 0 || exp_err_q.size() != 0) && t < 1000) begin
      @(negedge clock);
      t++;
    end
    check("pending_expectations", 16'(exp_cmd_q.size() + exp_err_q.size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
